countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Run/pause/clear controller for a two-digit BCD countdown timer clocked at 1 Hz. It sequences a cascaded pair of down-counting decade digits through load, run, pause and expiry phases. It drives the BCD digit values consumed by the downstream 7-segment decoders, plus done/alarm status. It sits between the user-input conditioning logic and the display path.

## Interface
- `AUTO_RELOAD`, default 0: 1 = on expiry, reload the preset and restart automatically.
- `clk_1Hz` input 1: timer clock, rising-edge active.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: level, sampled on each clock edge; begins or resumes counting.
- `pause` input 1: level; freezes counting while in RUN.
- `clear` input 1: level; aborts to IDLE and zeroes the digits.
- `preset_tens` input 4: BCD tens digit of the countdown start value.
- `preset_ones` input 4: BCD ones digit of the countdown start value.
- `tens` output 4: current tens digit, BCD 0–9.
- `ones` output 4: current ones digit, BCD 0–9.
- `running` output 1: high while the state is RUN.
- `done` output 1: high while the state is DONE.
- `alarm` output 1: blinking expiry indicator; see Configuration.
- `state` output 3: encodings IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Reset: state=IDLE; tens=0, ones=0; running=0, done=0, alarm=0.
- Input priority on each edge: clear > start > pause.
- clear from any state: go to IDLE next edge, digits set to 00, done=0, alarm=0.
- IDLE: digits hold 00. start=1 → LOAD.
- LOAD (exactly one cycle):
  - Digits take the preset values; any preset digit >9 is clamped to 9.
  - Loaded value 00 → DONE; otherwise → RUN.
- RUN, with pause=0: decrement by one each edge.
  - ones>0: ones−1.
  - ones=0: ones=9, tens−1.
  - Value 01 decrements to 00 and the state enters DONE on the same edge.
- RUN, with pause=1: → PAUSE; no decrement on that edge.
- PAUSE: digits hold. start=1 → RUN; no decrement on the resuming edge. pause is ignored in PAUSE.
- DONE: digits 00, done=1.
  - start=1 → LOAD.
  - AUTO_RELOAD=1: → LOAD on the edge after entry, unconditionally.
- The counter never underflows below 00 and never produces a non-BCD digit.
- start and pause both high in RUN: start wins; the state stays RUN and counting continues.
- Unused state encodings (5–7) recover to IDLE on the next edge.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- start sampled high at edge N in IDLE:
  - State is LOAD after edge N.
  - Digits equal the preset after edge N+1.
  - First decrement occurs at edge N+2.
- A preset of T (decimal, nonzero) reaches 00 and done=1 after edge N+1+T.
- clear takes effect at the edge where it is sampled, including mid-RUN and mid-LOAD.
- rst_n asserted mid-operation forces the reset values immediately, independent of the clock. Deassertion is released to the next rising edge.

## Configuration
- `COUNTDOWN_ALARM_EN` defined: `alarm` toggles on every edge while in DONE. It starts at 1 on the DONE entry edge and clears to 0 on leaving DONE.
- `COUNTDOWN_ALARM_EN` undefined: `alarm` is constant 0 and the toggle register is not built. All other behaviour is identical.

## Structure
- Shared package `countdown_pkg` holds:
  - the state enum (IDLE/LOAD/RUN/PAUSE/DONE with the encodings above);
  - BCD constants BCD_MAX=4'd9 and BCD_ZERO=4'd0;
  - the clamp function for preset digits.
- Sub-module `bcd_digit_dn`: one decade down-counter digit with load, enable, borrow-in and borrow-out (borrow_out = enable & digit==0). It is instantiated twice, with the ones borrow_out driving the tens enable.
- The FSM and output registers live in `countdown_ctrl`.

## Test plan
- Reset, then start=1 for one edge with preset 1,2: LOAD then RUN. Digits step 12, 11, 10, 09 … 01, 00. done=1 after edge N+13; running drops on the same edge.
- Preset 0,0 and start: LOAD → DONE directly. Digits stay 00 and no decrement occurs.
- Preset 2,5; run 5 cycles (digits 20); pause for 3 edges: digits hold 20, state=PAUSE. Then start: next edge digits still 20, following edge 19.
- Preset 1,5 with preset_ones driven to 4'hC: digits load as 19 and count down normally.
- clear asserted while running at 07 with start also high: IDLE and 00 next edge. Async rst_n pulse mid-RUN: outputs zero immediately.
- AUTO_RELOAD=1, preset 0,3, COUNTDOWN_ALARM_EN defined: digits 03, 02, 01, 00. DONE lasts one cycle with alarm=1, then LOAD reloads 03 and alarm returns to 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types, BCD constants and the preset clamp for the countdown timer.
package countdown_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  // Out-of-range preset digits saturate to 9 so the counter only sees BCD.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between input conditioning (master) and the timer controller (slave).
interface countdown_ctrl_if;
  import countdown_pkg::*;

  logic   start;
  logic   pause;
  logic   clear;
  bcd_t   preset_tens;
  bcd_t   preset_ones;
  bcd_t   tens;
  bcd_t   ones;
  logic   running;
  logic   done;
  logic   alarm;
  state_t state;

  modport master (
    output start, pause, clear, preset_tens, preset_ones,
    input  tens, ones, running, done, alarm, state
  );

  modport slave (
    input  start, pause, clear, preset_tens, preset_ones,
    output tens, ones, running, done, alarm, state
  );

endinterface

// File: rtl/bcd_digit_dn.sv
// One decade down-counter digit; wraps 0->9 only when a higher digit can lend (borrow_in).
module bcd_digit_dn
  import countdown_pkg::*;
(
  input  logic clk_1Hz,
  input  logic rst_n,
  input  logic load,
  input  bcd_t load_val,
  input  logic enable,
  input  logic borrow_in,
  output bcd_t digit,
  output logic borrow_out
);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_val;
    end else if (enable) begin
      if (digit != BCD_ZERO) begin
        digit <= digit - 4'd1;
      end else if (borrow_in) begin
        digit <= BCD_MAX;
      end
    end
  end

  assign borrow_out = enable & (digit == BCD_ZERO);

endmodule

// File: rtl/countdown_ctrl.sv
// Run/pause/clear controller for a two-digit BCD countdown at 1 Hz.
// Build option: define COUNTDOWN_ALARM_EN to get a blinking alarm while in DONE.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
)
(
  input  logic             clk_1Hz,
  input  logic             rst_n,
  countdown_ctrl_if.slave  bus
);

  state_t    state_q;
  state_t    state_d;
  logic      step;
  logic      load;
  logic      load_zero;
  logic      expire;
  bcd_t      tens_q;
  bcd_t      ones_q;
  logic      ones_borrow;
  logic      tens_borrow_unused;
  bcd_pair_t preset_c;
  bcd_pair_t load_val;
  logic      running_q;
  logic      done_q;

  assign preset_c.tens = bcd_clamp(bus.preset_tens);
  assign preset_c.ones = bcd_clamp(bus.preset_ones);
  assign load_val      = load_zero ? '0 : preset_c;
  assign expire        = (tens_q == BCD_ZERO) && (ones_q == 4'd1);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter controls; clear outranks start, start outranks pause.
  always_comb begin
    state_d   = state_q;
    step      = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    if (bus.clear) begin
      state_d   = IDLE;
      load      = 1'b1;
      load_zero = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = LOAD;
        end
        LOAD: begin
          load    = 1'b1;
          state_d = (preset_c == '0) ? DONE : RUN;
        end
        RUN: begin
          if (bus.start || !bus.pause) begin
            step = 1'b1;
            if (expire) state_d = DONE;
          end else begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        DONE: begin
          if (AUTO_RELOAD || bus.start) state_d = LOAD;
        end
        default: begin
          state_d   = IDLE;
          load      = 1'b1;
          load_zero = 1'b1;
        end
      endcase
    end
  end

  // Ones wraps only while tens is nonzero, so 00 can never underflow.
  bcd_digit_dn u_ones (
    .clk_1Hz    (clk_1Hz),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val.ones),
    .enable     (step),
    .borrow_in  (tens_q != BCD_ZERO),
    .digit      (ones_q),
    .borrow_out (ones_borrow)
  );

  bcd_digit_dn u_tens (
    .clk_1Hz    (clk_1Hz),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val.tens),
    .enable     (ones_borrow),
    .borrow_in  (1'b0),
    .digit      (tens_q),
    .borrow_out (tens_borrow_unused)
  );

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

`ifdef COUNTDOWN_ALARM_EN
  logic alarm_q;

  // Set on DONE entry, toggles while DONE persists, cleared on exit.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (state_d == DONE) begin
      alarm_q <= (state_q == DONE) ? ~alarm_q : 1'b1;
    end else begin
      alarm_q <= 1'b0;
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

  assign bus.state   = state_q;
  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: one instance with AUTO_RELOAD=0, one with AUTO_RELOAD=1.
module tb_countdown_ctrl;
  import countdown_pkg::*;

`ifdef COUNTDOWN_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] t;
    logic [3:0] o;
    logic       run;
    logic       dn;
    logic       al;
  } exp_t;

  typedef struct {
    bit   start;
    bit   pause;
    bit   clear;
    exp_t e;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  countdown_ctrl_if a_if ();
  countdown_ctrl_if b_if ();

  countdown_ctrl #(.AUTO_RELOAD(1'b0)) u_a (
    .clk_1Hz (clk),
    .rst_n   (rst_n),
    .bus     (a_if.slave)
  );

  countdown_ctrl #(.AUTO_RELOAD(1'b1)) u_b (
    .clk_1Hz (clk),
    .rst_n   (rst_n),
    .bus     (b_if.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs for a state and a decimal value; running/done follow the state.
  function automatic exp_t mk(input int st, input int v, input bit al);
    exp_t r;
    r.st  = 3'(st);
    r.t   = 4'(v / 10);
    r.o   = 4'(v % 10);
    r.run = (st == 2);
    r.dn  = (st == 4);
    r.al  = al;
    return r;
  endfunction

  function automatic exp_t smp_a();
    exp_t r;
    r.st  = a_if.state;
    r.t   = a_if.tens;
    r.o   = a_if.ones;
    r.run = a_if.running;
    r.dn  = a_if.done;
    r.al  = a_if.alarm;
    return r;
  endfunction

  function automatic exp_t smp_b();
    exp_t r;
    r.st  = b_if.state;
    r.t   = b_if.tens;
    r.o   = b_if.ones;
    r.run = b_if.running;
    r.dn  = b_if.done;
    r.al  = b_if.alarm;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, g;
    rst_n = 1'b0;
    #2;
    sb.push_back(mk(IDLE, 0, 1'b0));
    sb.push_back(mk(IDLE, 0, 1'b0));
    e = sb.pop_front(); g = smp_a(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_a: got st=%0d digits=%0d%0d flags=%b want st=%0d digits=%0d%0d flags=%b",
               g.st, g.t, g.o, {g.run, g.dn, g.al}, e.st, e.t, e.o, {e.run, e.dn, e.al});
    end
    e = sb.pop_front(); g = smp_b(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_b: got st=%0d digits=%0d%0d flags=%b want st=%0d digits=%0d%0d flags=%b",
               g.st, g.t, g.o, {g.run, g.dn, g.al}, e.st, e.t, e.o, {e.run, e.dn, e.al});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives a stimulus table into instance A one edge per entry and scores each edge.
  task automatic run_a(input string name, input stim_t q[$]);
    exp_t e, g;
    foreach (q[i]) begin
      a_if.start = q[i].start;
      a_if.pause = q[i].pause;
      a_if.clear = q[i].clear;
      sb.push_back(q[i].e);
      tick();
      e = sb.pop_front(); g = smp_a(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got st=%0d digits=%0d%0d flags=%b want st=%0d digits=%0d%0d flags=%b",
                 name, i, g.st, g.t, g.o, {g.run, g.dn, g.al}, e.st, e.t, e.o, {e.run, e.dn, e.al});
      end
    end
    a_if.start = 1'b0;
    a_if.pause = 1'b0;
    a_if.clear = 1'b0;
  endtask

  task automatic test_count_down();
    stim_t q[$];
    a_if.preset_tens = 4'd1;
    a_if.preset_ones = 4'd2;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 12, 1'b0)});
    for (int v = 11; v >= 1; v--) q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, v, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, ALARM_ON)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    run_a("count12", q);
  endtask

  task automatic test_zero_preset();
    stim_t q[$];
    a_if.preset_tens = 4'd0;
    a_if.preset_ones = 4'd0;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, ALARM_ON)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, ALARM_ON)});
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, ALARM_ON)});
    q.push_back('{1'b0, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    run_a("zero", q);
  endtask

  task automatic test_pause();
    stim_t q[$];
    a_if.preset_tens = 4'd2;
    a_if.preset_ones = 4'd5;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 25, 1'b0)});
    for (int v = 24; v >= 20; v--) q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, v, 1'b0)});
    for (int k = 0; k < 3; k++) q.push_back('{1'b0, 1'b1, 1'b0, mk(PAUSE, 20, 1'b0)});
    q.push_back('{1'b1, 1'b0, 1'b0, mk(RUN, 20, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 19, 1'b0)});
    q.push_back('{1'b1, 1'b1, 1'b0, mk(RUN, 18, 1'b0)});
    q.push_back('{1'b0, 1'b1, 1'b0, mk(PAUSE, 18, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(PAUSE, 18, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    run_a("pause", q);
  endtask

  task automatic test_clamp_clear();
    stim_t q[$];
    a_if.preset_tens = 4'd1;
    a_if.preset_ones = 4'hC;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 19, 1'b0)});
    for (int v = 18; v >= 7; v--) q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, v, 1'b0)});
    q.push_back('{1'b1, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(IDLE, 0, 1'b0)});
    run_a("clamp_clear", q);
  endtask

  task automatic test_clear_in_load();
    stim_t q[$];
    a_if.preset_tens = 4'd3;
    a_if.preset_ones = 4'd3;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(IDLE, 0, 1'b0)});
    run_a("clear_load", q);
  endtask

  task automatic test_async_reset();
    stim_t q[$];
    exp_t  e, g;
    a_if.preset_tens = 4'd1;
    a_if.preset_ones = 4'd5;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 15, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 14, 1'b0)});
    run_a("pre_rst", q);
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(mk(IDLE, 0, 1'b0));
    e = sb.pop_front(); g = smp_a(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL async_rst: got st=%0d digits=%0d%0d flags=%b want st=%0d digits=%0d%0d flags=%b",
               g.st, g.t, g.o, {g.run, g.dn, g.al}, e.st, e.t, e.o, {e.run, e.dn, e.al});
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    q.push_back('{1'b0, 1'b0, 1'b0, mk(IDLE, 0, 1'b0)});
    run_a("post_rst", q);
  endtask

  task automatic test_auto_reload();
    stim_t q[$];
    exp_t  e, g;
    b_if.preset_tens = 4'd0;
    b_if.preset_ones = 4'd3;
    q.push_back('{1'b1, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 3, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 2, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 1, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(DONE, 0, ALARM_ON)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(LOAD, 0, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 3, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b0, mk(RUN, 2, 1'b0)});
    q.push_back('{1'b0, 1'b0, 1'b1, mk(IDLE, 0, 1'b0)});
    foreach (q[i]) begin
      b_if.start = q[i].start;
      b_if.pause = q[i].pause;
      b_if.clear = q[i].clear;
      sb.push_back(q[i].e);
      tick();
      e = sb.pop_front(); g = smp_b(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reload[%0d]: got st=%0d digits=%0d%0d flags=%b want st=%0d digits=%0d%0d flags=%b",
                 i, g.st, g.t, g.o, {g.run, g.dn, g.al}, e.st, e.t, e.o, {e.run, e.dn, e.al});
      end
    end
    b_if.start = 1'b0;
    b_if.clear = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    a_if.start = 1'b0; a_if.pause = 1'b0; a_if.clear = 1'b0;
    a_if.preset_tens = 4'd0; a_if.preset_ones = 4'd0;
    b_if.start = 1'b0; b_if.pause = 1'b0; b_if.clear = 1'b0;
    b_if.preset_tens = 4'd0; b_if.preset_ones = 4'd0;

    test_reset();
    test_count_down();
    test_zero_preset();
    test_pause();
    test_clamp_clear();
    test_clear_in_load();
    test_async_reset();
    test_auto_reload();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
